// File: rtl/kmeans_pkg.sv
// Shared constants and state encoding for the k-means cluster engine and mean updater.
package kmeans_pkg;

  localparam int unsigned CH_W   = 8;
  localparam int unsigned SUM_W  = 24;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned MEAN_W = 24;
  localparam int unsigned ACC_W  = 72;
  localparam int unsigned DIV_STEPS = SUM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_STORE,
    ST_DONE
  } upd_state_t;

  // Empty clusters keep their old channel; large quotients clamp to full scale.
  function automatic logic [CH_W-1:0] sat_chan(input logic [SUM_W-1:0] q,
                                               input logic [CH_W-1:0]  old,
                                               input logic             empty);
    if (empty)
      return old;
    if (|q[SUM_W-1:CH_W])
      return '1;
    return q[CH_W-1:0];
  endfunction

endpackage

// File: rtl/kmeans_mean_updater_if.sv
// Bundle between the iteration controller/engine and the mean updater.
interface kmeans_mean_updater_if import kmeans_pkg::*; #(parameter int unsigned T = 16);

  logic                  start;
  logic                  init_valid;
  logic [MEAN_W*T-1:0]   init_means;
  logic [ACC_W*T-1:0]    accumulator;
  logic [CNT_W*T-1:0]    counters;
  logic [MEAN_W*T-1:0]   means;
  logic                  busy;
  logic                  done;
  logic                  changed;
  logic                  clear_acc;

  modport master (
    output start, init_valid, init_means, accumulator, counters,
    input  means, busy, done, changed, clear_acc
  );

  modport slave (
    input  start, init_valid, init_means, accumulator, counters,
    output means, busy, done, changed, clear_acc
  );

endinterface

// File: rtl/serial_divider.sv
// 24/12 unsigned restoring divider, one quotient bit per step, MSB first.
module serial_divider import kmeans_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient
);

  logic [CNT_W:0]   rem_q;
  logic [SUM_W-1:0] quo_q;
  logic [CNT_W-1:0] dvs_q;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_sub;
  logic             fits;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    rem_sh  = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? rem_sub : rem_sh;
      quo_q <= {quo_q[SUM_W-2:0], fits};
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/kmeans_mean_updater.sv
// Recomputes every cluster mean as sum/count and reports whether any mean moved.
module kmeans_mean_updater import kmeans_pkg::*; #(
  parameter int unsigned T = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  kmeans_mean_updater_if.slave  bus
);

  localparam int unsigned   IW   = (T > 1) ? $clog2(T) : 1;
  localparam logic [IW-1:0] LAST = IW'(T - 1);

  upd_state_t          state_q, state_n;
  logic [IW-1:0]       idx_q;
  logic [4:0]          step_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [MEAN_W*T-1:0] means_q;
  logic                busy_q, done_q, changed_q, clear_q;

  logic                div_load, div_step;
  logic [ACC_W-1:0]    acc_sel;
  logic [CNT_W-1:0]    cnt_sel;
  logic [SUM_W-1:0]    q_r, q_g, q_b;
  logic [MEAN_W-1:0]   old_mean, new_mean;

  always_comb begin
    acc_sel  = bus.accumulator[ACC_W*idx_q +: ACC_W];
    cnt_sel  = bus.counters[CNT_W*idx_q +: CNT_W];
    old_mean = means_q[MEAN_W*idx_q +: MEAN_W];
    new_mean = {sat_chan(q_r, old_mean[23:16], cnt_q == '0),
                sat_chan(q_g, old_mean[15:8],  cnt_q == '0),
                sat_chan(q_b, old_mean[7:0],   cnt_q == '0)};
  end

  serial_divider u_div_r (
    .clk(clk), .reset(reset), .load(div_load), .step(div_step),
    .dividend(acc_sel[71:48]), .divisor(cnt_sel), .quotient(q_r)
  );

  serial_divider u_div_g (
    .clk(clk), .reset(reset), .load(div_load), .step(div_step),
    .dividend(acc_sel[47:24]), .divisor(cnt_sel), .quotient(q_g)
  );

  serial_divider u_div_b (
    .clk(clk), .reset(reset), .load(div_load), .step(div_step),
    .dividend(acc_sel[23:0]), .divisor(cnt_sel), .quotient(q_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.init_valid && bus.start)
          state_n = ST_LOAD;
      end
      ST_LOAD: begin
        div_load = 1'b1;
        state_n  = ST_DIV;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (step_q == 5'(DIV_STEPS - 1))
          state_n = ST_STORE;
      end
      ST_STORE: state_n = (idx_q == LAST) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      means_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= (state_n == ST_DONE);
      clear_q <= (state_n == ST_DONE);
      unique case (state_q)
        ST_IDLE: begin
          if (bus.init_valid) begin
            means_q   <= bus.init_means;
            changed_q <= 1'b0;
          end else if (bus.start) begin
            idx_q     <= '0;
            changed_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          cnt_q  <= cnt_sel;
          step_q <= '0;
        end
        ST_DIV: step_q <= step_q + 5'd1;
        ST_STORE: begin
          means_q[MEAN_W*idx_q +: MEAN_W] <= new_mean;
          if (new_mean != old_mean)
            changed_q <= 1'b1;
          if (idx_q != LAST)
            idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.means     = means_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.changed   = changed_q;
  assign bus.clear_acc = clear_q;

endmodule
